// File: rtl/alu_instruction_dispatcher.sv
// Assembles little-endian instruction bytes into a 48-bit word, screens it for the ALU opcode
// class and holds it on alu_inst while waiting (bounded) for alu_done.
module alu_instruction_dispatcher #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fb_valid,
    input  logic [7:0]  fb_data,
    output logic        fb_ready,
    output logic        alu_en,
    output logic [47:0] alu_inst,
    input  logic        alu_done,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {StCollect, StCheck, StIssue} state_e;

    localparam logic [7:0] TimeoutW = 8'(TIMEOUT);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [47:0] shadow_q;
    logic [7:0]  wait_q;
    logic        fb_ready_q;
    logic        alu_en_q;
    logic [47:0] alu_inst_q;
    logic        illegal_q;
    logic        timeout_q;
    logic [15:0] issue_count_q;

    // Byte 0 bit 3 selects the 6-byte immediate form; idx_q == 0 can never be the last byte.
    logic last_byte;
    assign last_byte = (idx_q != 3'd0) && (idx_q == (shadow_q[3] ? 3'd5 : 3'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StCollect;
            idx_q         <= 3'd0;
            shadow_q      <= 48'd0;
            wait_q        <= 8'd0;
            fb_ready_q    <= 1'b0;
            alu_en_q      <= 1'b0;
            alu_inst_q    <= 48'd0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            issue_count_q <= 16'd0;
        end else begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    fb_ready_q <= 1'b1;
                    if (fb_valid && fb_ready_q) begin
                        if (idx_q == 3'd0) begin
                            // Clearing on byte 0 keeps bits past a short instruction at zero.
                            shadow_q <= {40'd0, fb_data};
                            idx_q    <= 3'd1;
                        end else begin
                            shadow_q[{idx_q, 3'b000} +: 8] <= fb_data;
                            idx_q <= idx_q + 3'd1;
                        end
                        if (last_byte) begin
                            state_q    <= StCheck;
                            fb_ready_q <= 1'b0;
                            idx_q      <= 3'd0;
                        end
                    end
                end
                StCheck: begin
                    if (shadow_q[2:0] == 3'b100) begin
                        alu_inst_q <= shadow_q;
                        wait_q     <= 8'd0;
                        alu_en_q   <= 1'b1;
                        state_q    <= StIssue;
                    end else begin
                        illegal_q  <= 1'b1;
                        fb_ready_q <= 1'b1;
                        state_q    <= StCollect;
                    end
                end
                StIssue: begin
                    // alu_done takes priority over an expiring wait.
                    if (alu_done) begin
                        issue_count_q <= issue_count_q + 16'd1;
                        alu_en_q      <= 1'b0;
                        fb_ready_q    <= 1'b1;
                        state_q       <= StCollect;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                        if (wait_q + 8'd1 == TimeoutW) begin
                            timeout_q  <= 1'b1;
                            alu_en_q   <= 1'b0;
                            fb_ready_q <= 1'b1;
                            state_q    <= StCollect;
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign fb_ready    = fb_ready_q;
    assign alu_en      = alu_en_q;
    assign alu_inst    = alu_inst_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_instruction_dispatcher.sv
// Bench for alu_instruction_dispatcher: byte-queue reference model compared every cycle, plus
// directed instruction sequences with hand-computed results.
module tb_alu_instruction_dispatcher;

    localparam int unsigned TO = 3;

    logic        clk;
    logic        rst;
    logic        fb_valid;
    logic [7:0]  fb_data;
    logic        fb_ready;
    logic        alu_en;
    logic [47:0] alu_inst;
    logic        alu_done;
    logic        illegal;
    logic        timeout;
    logic [15:0] issue_count;

    logic done_tie;
    logic done_val;
    assign alu_done = done_tie ? alu_en : done_val;

    alu_instruction_dispatcher #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fb_valid   (fb_valid),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .alu_en     (alu_en),
        .alu_inst   (alu_inst),
        .alu_done   (alu_done),
        .illegal    (illegal),
        .timeout    (timeout),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction bytes kept as a queue, phase 0/1/2 = collect/check/issue.
    logic [7:0]  m_bytes[$];
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [47:0] m_inst  = '0;
    logic [47:0] m_sh    = '0;
    logic [15:0] m_count = '0;
    logic        m_ready = 1'b0;
    logic        m_en    = 1'b0;
    logic        m_ill   = 1'b0;
    logic        m_to    = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_bytes.delete();
            m_phase = 0; m_wait = 0; m_inst = '0; m_count = '0;
            m_ready = 1'b0; m_en = 1'b0; m_ill = 1'b0; m_to = 1'b0;
        end else begin
            m_ill = 1'b0;
            m_to  = 1'b0;
            case (m_phase)
                0: if (fb_valid && m_ready) begin
                    m_bytes.push_back(fb_data);
                    if (m_bytes.size() == (m_bytes[0][3] ? 6 : 2)) m_phase = 1;
                end
                1: begin
                    m_sh = '0;
                    foreach (m_bytes[i]) m_sh = m_sh | (48'(m_bytes[i]) << (8 * i));
                    m_bytes.delete();
                    if (m_sh[2:0] == 3'b100) begin
                        m_inst = m_sh; m_wait = 0; m_phase = 2;
                    end else begin
                        m_ill = 1'b1; m_phase = 0;
                    end
                end
                default: begin
                    if (alu_done) begin
                        m_count = m_count + 16'd1; m_phase = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == int'(TO)) begin
                            m_to = 1'b1; m_phase = 0;
                        end
                    end
                end
            endcase
            m_ready = (m_phase == 0);
            m_en    = (m_phase == 2);
        end
    end

    int n_ill_p = 0;
    int n_to_p  = 0;
    int en_run  = 0;
    int en_len  = 0;

    initial forever begin
        @(negedge clk);
        chk("fb_ready", 64'(fb_ready), 64'(m_ready));
        chk("alu_en", 64'(alu_en), 64'(m_en));
        chk("alu_inst", 64'(alu_inst), 64'(m_inst));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("issue_count", 64'(issue_count), 64'(m_count));
        if (illegal) n_ill_p++;
        if (timeout) n_to_p++;
        if (alu_en) en_run++;
        else if (en_run > 0) begin
            en_len = en_run;
            en_run = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!fb_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_bound", 64'(fb_ready), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        fb_valid = 1'b1;
        fb_data  = b;
        @(negedge clk);
        fb_valid = 1'b0;
    endtask

    task automatic finish_issue();
        wait_ready();
        @(negedge clk);
    endtask

    int ill0;
    int to0;
    int n;

    initial begin
        rst = 1'b1; fb_valid = 1'b0; fb_data = 8'h00; done_tie = 1'b1; done_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fb_ready", 64'(fb_ready), 64'd0);
        chk("rst_alu_inst", 64'(alu_inst), 64'd0);
        chk("rst_issue_count", 64'(issue_count), 64'd0);
        #2 rst = 1'b0;
        #1 chk("ready_before_edge", 64'(fb_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(fb_ready), 64'd1);

        // Register ADD
        send_byte(8'h84); send_byte(8'h21); finish_issue();
        chk("add_inst", 64'(alu_inst), 64'h0000_0000_2184);
        chk("add_en_len", 64'(en_len), 64'd1);
        chk("add_count", 64'(issue_count), 64'd1);

        // Immediate ADD with a 2-cycle gap
        send_byte(8'h8C); send_byte(8'h03); send_byte(8'h78);
        repeat (2) @(negedge clk);
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); finish_issue();
        chk("imm_inst", 64'(alu_inst), 64'h0000_1234_5678_038C);
        chk("imm_count", 64'(issue_count), 64'd2);

        // Non-ALU 2-byte, then normal
        ill0 = n_ill_p;
        send_byte(8'h81); send_byte(8'h00); finish_issue();
        chk("ill_pulses", 64'(n_ill_p - ill0), 64'd1);
        chk("ill_inst_held", 64'(alu_inst), 64'h0000_1234_5678_038C);
        chk("ill_count", 64'(issue_count), 64'd2);
        send_byte(8'h84); send_byte(8'h21); finish_issue();
        chk("post_ill_inst", 64'(alu_inst), 64'h0000_0000_2184);
        chk("post_ill_count", 64'(issue_count), 64'd3);

        // Non-ALU 6-byte form
        ill0 = n_ill_p;
        send_byte(8'h8B); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h55); finish_issue();
        chk("ill6_pulses", 64'(n_ill_p - ill0), 64'd1);
        chk("ill6_count", 64'(issue_count), 64'd3);

        // Timeout with done held low
        done_tie = 1'b0; done_val = 1'b0; to0 = n_to_p;
        send_byte(8'h84); send_byte(8'h21); finish_issue();
        chk("to_en_len", 64'(en_len), 64'd3);
        chk("to_pulses", 64'(n_to_p - to0), 64'd1);
        chk("to_count", 64'(issue_count), 64'd3);

        // Done arriving in the last allowed cycle wins
        to0 = n_to_p;
        send_byte(8'h84); send_byte(8'h21);
        n = 0;
        while (!alu_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("en_seen", 64'(alu_en), 64'd1);
        repeat (2) @(negedge clk);
        done_val = 1'b1;
        @(negedge clk);
        done_val = 1'b0;
        finish_issue();
        chk("late_en_len", 64'(en_len), 64'd3);
        chk("late_count", 64'(issue_count), 64'd4);
        chk("late_no_to", 64'(n_to_p - to0), 64'd0);
        done_tie = 1'b1;

        // Reset mid-collection
        ill0 = n_ill_p; to0 = n_to_p;
        send_byte(8'h8C); send_byte(8'h03); send_byte(8'h78); send_byte(8'h56);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_inst", 64'(alu_inst), 64'd0);
        chk("mid_rst_count", 64'(issue_count), 64'd0);
        chk("mid_rst_ready", 64'(fb_ready), 64'd0);
        chk("mid_rst_en", 64'(alu_en), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        send_byte(8'h84); send_byte(8'h21); finish_issue();
        chk("post_rst_inst", 64'(alu_inst), 64'h0000_0000_2184);
        chk("post_rst_count", 64'(issue_count), 64'd1);
        chk("post_rst_no_pulse", 64'((n_ill_p - ill0) + (n_to_p - to0)), 64'd0);

        // issue_count wrap
        @(negedge clk);
        force dut.issue_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        @(negedge clk);
        release dut.issue_count_q;
        @(negedge clk);
        chk("preload_count", 64'(issue_count), 64'hFFFF);
        send_byte(8'h84); send_byte(8'h21); finish_issue();
        chk("wrap_count", 64'(issue_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
